branch_target_buffer_assoc: RTL and testbench
=============================================

Name: branch_target_buffer_assoc

Overview:
Parametrised, set-associative branch target buffer with per-entry valid bits, a full-tag compare and 2-bit saturating direction counters.
- Fetch looks it up with `current_pc`; the result is registered.
- The resolve stage updates it with `prev_pc` and the resolved outcome (taken branch, not-taken branch, jump).
- It adds what the direct-mapped predecessor lacks: associativity, round-robin replacement, hysteresis, an explicit hit flag and a whole-table flush.

Parameters:
- ADDR_W, 64, PC and target width in bits.
- SETS, 8, number of sets; power of two, >= 2.
- WAYS, 2, ways per set; one of 1, 2, 4.
- IDX_W, log2(SETS), derived (localparam), index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, no state changes and output registers hold.
- flush  in  1  clears all valid bits.
- current_pc  in  ADDR_W  fetch PC to look up.
- prev_pc  in  ADDR_W  PC of the resolved control-flow instruction.
- branch_pc  in  ADDR_W  resolved branch target.
- jump_pc  in  ADDR_W  resolved jump target.
- was_taken  in  1  resolved conditional branch, taken.
- not_taken  in  1  resolved conditional branch, not taken.
- jumped  in  1  resolved unconditional jump.
- pred_hit  out  1  registered: tag match on a valid entry.
- pred_taken  out  1  registered: hit and counter MSB = 1.
- predicted_branch_pc  out  ADDR_W  registered: target when pred_taken, else 0.

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] are ignored.
- Storage per entry: valid, tag, target (ADDR_W), ctr (2 bit). Per set: a round-robin pointer of log2(WAYS) bits; absent when WAYS=1.
- Reset (rst=1 at posedge): all valid=0, all ctr=0, all pointers=0, pred_hit=0, pred_taken=0, predicted_branch_pc=0. rst has priority over en and flush.
- Lookup latency is 1 cycle. Outputs at posedge N+1 reflect `current_pc` sampled at posedge N, evaluated against table contents before any update in that same cycle (read-before-write, no bypass).
- Multiple ways matching the same tag cannot arise by construction. If it does, the lowest way wins.
- Update, evaluated when en=1; one-hot among was_taken/not_taken/jumped. If more than one is set, priority is jumped > was_taken > not_taken.
  - jumped, hit: target <= jump_pc; ctr <= 2'b11.
  - jumped, miss: allocate; target <= jump_pc; ctr <= 2'b11.
  - was_taken, hit: target <= branch_pc; ctr <= sat_inc(ctr), saturating at 3.
  - was_taken, miss: allocate; target <= branch_pc; ctr <= 2'b10.
  - not_taken, hit: ctr <= sat_dec(ctr), saturating at 0. The entry stays valid.
  - not_taken, miss: no change.
- Allocation victim: the lowest-numbered invalid way in the set. If all ways are valid, the way at the set's pointer, and the pointer then advances modulo WAYS. The pointer advances only on allocation into a full set.
- flush=1 with en=1: all valid <= 0 and outputs <= 0 that cycle; any update in the same cycle is discarded. Pointers and ctr are not cleared.
- en=0: table, pointers and outputs hold.
- Lookup and update to the same set in the same cycle: the lookup sees old contents; the update commits at that edge.

Test Plan:
- Reset, then lookup current_pc=0x1000 -> pred_hit=0, pred_taken=0, predicted_branch_pc=0 one cycle later.
- Taken branch prev_pc=0x1000, branch_pc=0x1400; next cycle look up 0x1000 -> pred_hit=1, pred_taken=1 (ctr=2), predicted_branch_pc=0x1400. Lookup 0x1004 -> pred_hit=0.
- Aliasing (SETS=8, WAYS=2): 0x1000 is allocated, then taken branches at 0x2000 and 0x3000, all index 0.
  - After 0x2000: 0x1000 and 0x2000 both hit.
  - After 0x3000: it replaces way 0 (pointer=0) -> 0x1000 misses, 0x2000 and 0x3000 hit.
- Hysteresis: entry with ctr=2, apply not_taken at 0x1000 -> pred_hit=1, pred_taken=0, predicted_branch_pc=0. A second not_taken leaves ctr=0. Then was_taken -> ctr=1, still pred_taken=0. Another was_taken -> pred_taken=1.
- Jump and priority: jumped=1 together with was_taken=1 at 0x2040, jump_pc=0x8000, branch_pc=0x9000 -> lookup 0x2040 gives 0x8000, pred_taken=1.
- Same-cycle update/lookup on 0x1000 -> outputs show pre-update result. The following lookup shows the new one.
- flush=1 while an update is presented -> the update is dropped and every lookup misses.
- en=0 -> outputs frozen and no allocation.
- rst asserted mid-stream with en=1 -> all outputs 0 and all entries miss afterwards.

Source files
------------

// File: rtl/branch_target_buffer_assoc_if.sv
// Fetch/resolve bus of the set-associative branch target buffer.
// No valid/ready pair: a lookup is issued every enabled cycle, and the update strobes are qualified by en.
interface branch_target_buffer_assoc_if #(
   parameter int ADDR_W = 64
);
   logic              en;
   logic              flush;
   logic [ADDR_W-1:0] current_pc;
   logic [ADDR_W-1:0] prev_pc;
   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] jump_pc;
   logic              was_taken;
   logic              not_taken;
   logic              jumped;
   logic              pred_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] predicted_branch_pc;

   modport master (
      output en, flush, current_pc, prev_pc, branch_pc, jump_pc,
      output was_taken, not_taken, jumped,
      input  pred_hit, pred_taken, predicted_branch_pc
   );

   modport slave (
      input  en, flush, current_pc, prev_pc, branch_pc, jump_pc,
      input  was_taken, not_taken, jumped,
      output pred_hit, pred_taken, predicted_branch_pc
   );
endinterface

// File: rtl/branch_target_buffer_assoc.sv
// Set-associative BTB: full-tag compare, 2-bit hysteresis counters, round-robin victim
// selection in full sets, registered lookup that reads the table before the same-edge update.
module branch_target_buffer_assoc #(
   parameter int ADDR_W = 64,
   parameter int SETS   = 8,
   parameter int WAYS   = 2
) (
   input logic                   clk,
   input logic                   rst,
   branch_target_buffer_assoc_if.slave bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [PTR_W-1:0] way_t;

   logic [WAYS-1:0]   valid_q  [SETS];
   logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
   logic [ADDR_W-1:0] target_q [SETS][WAYS];
   logic [1:0]        ctr_q    [SETS][WAYS];
   way_t              ptr_q    [SETS];

   logic              pred_hit_q;
   logic              pred_taken_q;
   logic [ADDR_W-1:0] pred_pc_q;

   logic [IDX_W-1:0]  lk_idx, up_idx;
   logic [TAG_W-1:0]  lk_tag, up_tag;
   logic              lk_hit, up_hit, set_full;
   way_t              lk_way, up_way, vic_way;

   logic              wr_en, wr_adv;
   way_t              wr_way;
   logic [ADDR_W-1:0] wr_tgt;
   logic [1:0]        wr_ctr;

   logic              unused_pc_bits;
   assign unused_pc_bits = ^{bus.current_pc[1:0], bus.prev_pc[1:0]};

   assign lk_idx = bus.current_pc[IDX_W+1:2];
   assign lk_tag = bus.current_pc[ADDR_W-1:IDX_W+2];
   assign up_idx = bus.prev_pc[IDX_W+1:2];
   assign up_tag = bus.prev_pc[ADDR_W-1:IDX_W+2];

   // Scanning from the top way down leaves the lowest matching way selected.
   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      up_hit = 1'b0;
      up_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
            lk_hit = 1'b1;
            lk_way = way_t'(w);
         end
         if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
            up_hit = 1'b1;
            up_way = way_t'(w);
         end
      end
   end

   always_comb begin
      vic_way  = ptr_q[up_idx];
      set_full = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[up_idx][w]) begin
            vic_way  = way_t'(w);
            set_full = 1'b0;
         end
      end
   end

   // Resolve-stage write decode; jumped outranks was_taken, which outranks not_taken.
   always_comb begin
      wr_en  = 1'b0;
      wr_adv = 1'b0;
      wr_way = up_way;
      wr_tgt = target_q[up_idx][up_way];
      wr_ctr = ctr_q[up_idx][up_way];
      if (bus.jumped) begin
         wr_en  = 1'b1;
         wr_tgt = bus.jump_pc;
         wr_ctr = 2'b11;
         if (!up_hit) begin
            wr_way = vic_way;
            wr_adv = set_full;
         end
      end else if (bus.was_taken) begin
         wr_en  = 1'b1;
         wr_tgt = bus.branch_pc;
         if (up_hit) begin
            wr_ctr = (ctr_q[up_idx][up_way] == 2'b11) ? 2'b11 : ctr_q[up_idx][up_way] + 2'd1;
         end else begin
            wr_way = vic_way;
            wr_ctr = 2'b10;
            wr_adv = set_full;
         end
      end else if (bus.not_taken && up_hit) begin
         wr_en  = 1'b1;
         wr_ctr = (ctr_q[up_idx][up_way] == 2'b00) ? 2'b00 : ctr_q[up_idx][up_way] - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
            for (int w = 0; w < WAYS; w++) begin
               ctr_q[s][w] <= 2'b00;
            end
         end
         pred_hit_q   <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_pc_q    <= '0;
      end else if (bus.en) begin
         if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[s] <= '0;
            end
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
         end else begin
            pred_hit_q   <= lk_hit;
            pred_taken_q <= lk_hit && ctr_q[lk_idx][lk_way][1];
            pred_pc_q    <= (lk_hit && ctr_q[lk_idx][lk_way][1]) ? target_q[lk_idx][lk_way] : '0;
            if (wr_en) begin
               valid_q[up_idx][wr_way]  <= 1'b1;
               tag_q[up_idx][wr_way]    <= up_tag;
               target_q[up_idx][wr_way] <= wr_tgt;
               ctr_q[up_idx][wr_way]    <= wr_ctr;
               if (wr_adv) begin
                  ptr_q[up_idx] <= (WAYS > 1) ? ptr_q[up_idx] + way_t'(1) : '0;
               end
            end
         end
      end
   end

   assign bus.pred_hit            = pred_hit_q;
   assign bus.pred_taken          = pred_taken_q;
   assign bus.predicted_branch_pc = pred_pc_q;
endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// Bench for branch_target_buffer_assoc: directed scenarios plus random traffic against a
// table-level reference model of the associative BTB.
module tb_branch_target_buffer_assoc;
   localparam int ADDR_W = 64;
   localparam int SETS   = 8;
   localparam int WAYS   = 2;
   localparam int IDX_W  = $clog2(SETS);

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   branch_target_buffer_assoc_if #(.ADDR_W(ADDR_W)) bus ();

   branch_target_buffer_assoc #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: whole-entry records indexed by set number and way number.
   bit          m_valid [SETS][WAYS];
   logic [63:0] m_tag   [SETS][WAYS];
   logic [63:0] m_tgt   [SETS][WAYS];
   int          m_ctr   [SETS][WAYS];
   int          m_ptr   [SETS];
   logic [65:0] m_out;
   logic [65:0] exp_q[$];

   function automatic logic [65:0] pack(input bit h, input bit t, input logic [63:0] pc);
      return {h, t, pc};
   endfunction

   function automatic logic [65:0] obs();
      return {bus.pred_hit, bus.pred_taken, bus.predicted_branch_pc};
   endfunction

   function automatic int find(input int s, input logic [63:0] t);
      int h = -1;
      for (int w = WAYS - 1; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) h = w;
      return h;
   endfunction

   function automatic void model_step(input bit r, input bit e, input bit f,
                                      input logic [63:0] cur, prev, bpc, jpc,
                                      input bit wt, nt, jp);
      int s, h, v;
      logic [63:0] t;
      if (r) begin
         for (int i = 0; i < SETS; i++) begin
            m_ptr[i] = 0;
            for (int w = 0; w < WAYS; w++) begin m_valid[i][w] = 0; m_ctr[i][w] = 0; end
         end
         m_out = '0;
         return;
      end
      if (!e) return;
      if (f) begin
         for (int i = 0; i < SETS; i++) for (int w = 0; w < WAYS; w++) m_valid[i][w] = 0;
         m_out = '0;
         return;
      end
      s = int'((cur >> 2) % SETS);
      h = find(s, cur >> (2 + IDX_W));
      if (h < 0) m_out = '0;
      else m_out = pack(1'b1, m_ctr[s][h] >= 2, (m_ctr[s][h] >= 2) ? m_tgt[s][h] : 64'h0);
      s = int'((prev >> 2) % SETS);
      t = prev >> (2 + IDX_W);
      h = find(s, t);
      if (jp || wt) begin
         if (h < 0) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) begin
               v = m_ptr[s];
               m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1;
            m_tag[s][v]   = t;
            m_ctr[s][v]   = jp ? 3 : 2;
            h = v;
         end else begin
            m_ctr[s][h] = jp ? 3 : ((m_ctr[s][h] < 3) ? m_ctr[s][h] + 1 : 3);
         end
         m_tgt[s][h] = jp ? jpc : bpc;
      end else if (nt && h >= 0) begin
         m_ctr[s][h] = (m_ctr[s][h] > 0) ? m_ctr[s][h] - 1 : 0;
      end
   endfunction

   // Driver: called at a falling edge, applies inputs, lets one rising edge pass, returns at the next fall.
   task automatic step(input bit r, input bit e, input bit f,
                       input logic [63:0] cur, prev, bpc, jpc,
                       input bit wt, nt, jp);
      rst = r; bus.en = e; bus.flush = f;
      bus.current_pc = cur; bus.prev_pc = prev; bus.branch_pc = bpc; bus.jump_pc = jpc;
      bus.was_taken = wt; bus.not_taken = nt; bus.jumped = jp;
      @(posedge clk);
      model_step(r, e, f, cur, prev, bpc, jpc, wt, nt, jp);
      @(negedge clk);
   endtask

   task automatic look(input logic [63:0] cur);
      step(0, 1, 0, cur, 64'h0, 64'h0, 64'h0, 0, 0, 0);
   endtask

   task automatic taken(input logic [63:0] prev, input logic [63:0] bpc);
      step(0, 1, 0, 64'h0, prev, bpc, 64'h0, 1, 0, 0);
   endtask

   task automatic nottaken(input logic [63:0] prev);
      step(0, 1, 0, 64'h0, prev, 64'h0, 64'h0, 0, 1, 0);
   endtask

   task automatic test_reset();
      step(1, 1, 0, 64'h1000, 64'h0, 64'h0, 64'h0, 0, 0, 0);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs(), 66'h0); end
      look(64'h1000);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL reset_lookup: got %h want %h", obs(), 66'h0); end
   endtask

   task automatic test_taken();
      taken(64'h1000, 64'h1400);
      look(64'h1000);
      checks++;
      if (obs() !== pack(1, 1, 64'h1400)) begin errors++; $display("FAIL taken_hit: got %h want %h", obs(), pack(1, 1, 64'h1400)); end
      look(64'h1004);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL taken_neighbour_miss: got %h want %h", obs(), 66'h0); end
   endtask

   task automatic test_alias();
      taken(64'h2000, 64'h2400);
      look(64'h1000);
      checks++;
      if (obs() !== pack(1, 1, 64'h1400)) begin errors++; $display("FAIL alias_1000_kept: got %h want %h", obs(), pack(1, 1, 64'h1400)); end
      look(64'h2000);
      checks++;
      if (obs() !== pack(1, 1, 64'h2400)) begin errors++; $display("FAIL alias_2000_hit: got %h want %h", obs(), pack(1, 1, 64'h2400)); end
      taken(64'h3000, 64'h3400);
      look(64'h1000);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL alias_1000_evicted: got %h want %h", obs(), 66'h0); end
      look(64'h2000);
      checks++;
      if (obs() !== pack(1, 1, 64'h2400)) begin errors++; $display("FAIL alias_2000_kept: got %h want %h", obs(), pack(1, 1, 64'h2400)); end
      look(64'h3000);
      checks++;
      if (obs() !== pack(1, 1, 64'h3400)) begin errors++; $display("FAIL alias_3000_hit: got %h want %h", obs(), pack(1, 1, 64'h3400)); end
   endtask

   task automatic test_hysteresis();
      logic [65:0] want [5];
      want[0] = pack(1, 1, 64'h1400);
      want[1] = pack(1, 0, 64'h0);
      want[2] = pack(1, 0, 64'h0);
      want[3] = pack(1, 0, 64'h0);
      want[4] = pack(1, 1, 64'h1400);
      for (int i = 0; i < 5; i++) begin
         if (i == 0 || i >= 3) taken(64'h1000, 64'h1400);
         else nottaken(64'h1000);
         look(64'h1000);
         checks++;
         if (obs() !== want[i]) begin errors++; $display("FAIL hysteresis_%0d: got %h want %h", i, obs(), want[i]); end
      end
   endtask

   task automatic test_jump_priority();
      step(0, 1, 0, 64'h0, 64'h2040, 64'h9000, 64'h8000, 1, 0, 1);
      look(64'h2040);
      checks++;
      if (obs() !== pack(1, 1, 64'h8000)) begin errors++; $display("FAIL jump_priority: got %h want %h", obs(), pack(1, 1, 64'h8000)); end
   endtask

   task automatic test_same_cycle();
      step(0, 1, 0, 64'h1000, 64'h1000, 64'h1800, 64'h0, 1, 0, 0);
      checks++;
      if (obs() !== pack(1, 1, 64'h1400)) begin errors++; $display("FAIL same_cycle_old: got %h want %h", obs(), pack(1, 1, 64'h1400)); end
      look(64'h1000);
      checks++;
      if (obs() !== pack(1, 1, 64'h1800)) begin errors++; $display("FAIL same_cycle_new: got %h want %h", obs(), pack(1, 1, 64'h1800)); end
   endtask

   task automatic test_flush();
      logic [63:0] pcs [3];
      pcs[0] = 64'h1000; pcs[1] = 64'h2040; pcs[2] = 64'h5000;
      step(0, 1, 1, 64'h1000, 64'h5000, 64'h5400, 64'h0, 1, 0, 0);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL flush_outputs: got %h want %h", obs(), 66'h0); end
      for (int i = 0; i < 3; i++) begin
         look(pcs[i]);
         checks++;
         if (obs() !== 66'h0) begin errors++; $display("FAIL flush_miss_%h: got %h want %h", pcs[i], obs(), 66'h0); end
      end
   endtask

   task automatic test_enable();
      taken(64'h1000, 64'h1400);
      look(64'h1000);
      checks++;
      if (obs() !== pack(1, 1, 64'h1400)) begin errors++; $display("FAIL enable_setup: got %h want %h", obs(), pack(1, 1, 64'h1400)); end
      step(0, 0, 0, 64'h1004, 64'h6000, 64'h6400, 64'h0, 1, 0, 0);
      checks++;
      if (obs() !== pack(1, 1, 64'h1400)) begin errors++; $display("FAIL enable_hold: got %h want %h", obs(), pack(1, 1, 64'h1400)); end
      look(64'h6000);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL enable_no_alloc: got %h want %h", obs(), 66'h0); end
   endtask

   function automatic logic [63:0] rand_pc();
      return 64'h4000_0000 + (64'($urandom_range(0, 3)) << 5)
             + (64'($urandom_range(0, 2)) << 2) + 64'($urandom_range(0, 3));
   endfunction

   task automatic test_random();
      logic [65:0] want;
      bit e, f, wt, nt, jp;
      for (int i = 0; i < 500; i++) begin
         e  = ($urandom_range(0, 9) != 0);
         f  = ($urandom_range(0, 39) == 0);
         wt = ($urandom_range(0, 2) == 0);
         nt = ($urandom_range(0, 2) == 0);
         jp = ($urandom_range(0, 5) == 0);
         step(0, e, f, rand_pc(), rand_pc(), 64'($urandom), 64'($urandom), wt, nt, jp);
         exp_q.push_back(m_out);
         want = exp_q.pop_front();
         checks++;
         if (obs() !== want) begin errors++; $display("FAIL random_%0d: got %h want %h", i, obs(), want); end
      end
   endtask

   task automatic test_midreset();
      logic [63:0] pcs [4];
      for (int i = 0; i < 4; i++) begin
         pcs[i] = 64'h4000_0000 + (64'(i) << 5) + (64'(i % 3) << 2);
         taken(pcs[i], 64'h7000 + 64'(i));
      end
      step(1, 1, 0, pcs[3], pcs[0], 64'h7777, 64'h0, 1, 0, 0);
      checks++;
      if (obs() !== 66'h0) begin errors++; $display("FAIL midreset_outputs: got %h want %h", obs(), 66'h0); end
      for (int i = 0; i < 4; i++) begin
         look(pcs[i]);
         checks++;
         if (obs() !== 66'h0 || m_out !== 66'h0) begin
            errors++; $display("FAIL midreset_miss_%0d: got %h want %h", i, obs(), 66'h0);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_taken();
      test_alias();
      test_hysteresis();
      test_jump_priority();
      test_same_cycle();
      test_flush();
      test_enable();
      test_random();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
